ibex_mem_port_arbiter: RTL and testbench

- Merges the Ibex instruction-fetch and data (LSU) memory interfaces onto one shared req/gnt/rvalid memory port, for single-ported memory systems.
- Sits between the core top level and the memory/bus host port.
- Arbitrates with data priority plus an instruction anti-starvation limit.
- Holds the winner's request stable until it is granted, and routes in-order responses back to the correct requester using an ID FIFO.

---
 rtl/ibex_mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_ibex_mem_port_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between the Ibex fetch and LSU interfaces.
// Data has priority, fetch gets an anti-starvation boost; in-order responses are steered by an ID FIFO.
module ibex_mem_port_arbiter #(
    parameter int MaxOutstanding = 2,
    parameter int StarveLimit    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic [6:0]  instr_rdata_intg_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [6:0]  data_wdata_intg_i,
    output logic [31:0] data_rdata_o,
    output logic [6:0]  data_rdata_intg_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [6:0]  mem_wdata_intg_o,
    input  logic [31:0] mem_rdata_i,
    input  logic [6:0]  mem_rdata_intg_i,
    input  logic        mem_err_i,
    output logic [3:0]  outstanding_o,
    output logic        spurious_rvalid_o
);
    localparam int IdxW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_e;

    state_e                    state, state_next;
    logic                      win_valid, win_data, win_req, grant;
    logic                      fifo_full, push, pop, head_id;
    logic [3:0]                count, starve_cnt;
    logic [IdxW-1:0]           wr_ptr, rd_ptr;
    logic [MaxOutstanding-1:0] ids;

    function automatic logic [IdxW-1:0] ptr_inc(input logic [IdxW-1:0] p);
        return (p == IdxW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign fifo_full = (count == 4'(MaxOutstanding));
    assign head_id   = ids[rd_ptr];
    assign pop       = mem_rvalid_i && (count != 4'd0);
    assign push      = grant;

    always_comb begin
        win_valid  = 1'b0;
        win_data   = 1'b0;
        state_next = state;
        case (state)
            LOCK_I: begin
                win_valid = 1'b1;
                win_data  = 1'b0;
            end
            LOCK_D: begin
                win_valid = 1'b1;
                win_data  = 1'b1;
            end
            default: begin
                if (data_req_i && (starve_cnt < 4'(StarveLimit))) begin
                    win_valid = 1'b1;
                    win_data  = 1'b1;
                end else if (instr_req_i) begin
                    win_valid = 1'b1;
                    win_data  = 1'b0;
                end else if (data_req_i) begin
                    win_valid = 1'b1;
                    win_data  = 1'b1;
                end
            end
        endcase

        win_req   = win_data ? data_req_i : instr_req_i;
        mem_req_o = win_valid && win_req && !fifo_full;
        grant     = mem_req_o && mem_gnt_i;

        // A requester may not drop req before gnt, so an ungranted winner (stalled or FIFO-blocked) is pinned.
        if (grant) begin
            state_next = IDLE;
        end else if ((state == IDLE) && win_valid && win_req) begin
            state_next = win_data ? LOCK_D : LOCK_I;
        end
    end

    assign instr_gnt_o      = grant && !win_data;
    assign data_gnt_o       = grant && win_data;
    assign mem_addr_o       = !win_valid ? 32'h0 : (win_data ? data_addr_i : instr_addr_i);
    assign mem_we_o         = win_valid && win_data && data_we_i;
    assign mem_be_o         = (win_valid && win_data) ? data_be_i : 4'h0;
    assign mem_wdata_o      = (win_valid && win_data) ? data_wdata_i : 32'h0;
    assign mem_wdata_intg_o = (win_valid && win_data) ? data_wdata_intg_i : 7'h0;

    assign instr_rvalid_o     = pop && !head_id;
    assign data_rvalid_o      = pop && head_id;
    assign spurious_rvalid_o  = mem_rvalid_i && (count == 4'd0);
    assign instr_rdata_o      = mem_rdata_i;
    assign instr_rdata_intg_o = mem_rdata_intg_i;
    assign instr_err_o        = mem_err_i;
    assign data_rdata_o       = mem_rdata_i;
    assign data_rdata_intg_o  = mem_rdata_intg_i;
    assign data_err_o         = mem_err_i;
    assign outstanding_o      = count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            count      <= 4'd0;
            starve_cnt <= 4'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state <= state_next;
            count <= count + {3'b000, push} - {3'b000, pop};
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (!instr_req_i || instr_gnt_o) begin
                starve_cnt <= 4'd0;
            end else if (starve_cnt < 4'(StarveLimit)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    // ID storage only matters while occupied, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push) ids[wr_ptr] <= win_data;
    end
endmodule

// File: tb/tb_ibex_mem_port_arbiter.sv
// Scoreboard bench for ibex_mem_port_arbiter: requester IDs are queued at grant and checked at rvalid.
module tb_ibex_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic [6:0]  instr_rdata_intg;
    logic        data_req, data_gnt, data_rvalid, data_we, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [6:0]  data_wdata_intg, data_rdata_intg;
    logic        mem_req, mem_gnt, mem_rvalid, mem_we, mem_err;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [6:0]  mem_wdata_intg, mem_rdata_intg;
    logic [3:0]  outstanding;
    logic        spurious;

    int n_cmp = 0;
    int n_err = 0;
    bit sb[$];
    bit exp_id;

    always #5 clk = ~clk;

    ibex_mem_port_arbiter #(.MaxOutstanding(2), .StarveLimit(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
        .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata),
        .instr_rdata_intg_o(instr_rdata_intg), .instr_err_o(instr_err),
        .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
        .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_wdata_intg_i(data_wdata_intg),
        .data_rdata_o(data_rdata), .data_rdata_intg_o(data_rdata_intg), .data_err_o(data_err),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wdata_intg_o(mem_wdata_intg),
        .mem_rdata_i(mem_rdata), .mem_rdata_intg_i(mem_rdata_intg), .mem_err_i(mem_err),
        .outstanding_o(outstanding), .spurious_rvalid_o(spurious)
    );

    task automatic idle_inputs();
        instr_req = 0; instr_addr = 0;
        data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0; data_wdata_intg = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; mem_rdata_intg = 0; mem_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk); #1;
        n_cmp++; if ({mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid, spurious} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 000000", {mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid, spurious});
        end
        n_cmp++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        @(negedge clk); idle_inputs(); instr_req = 1; instr_addr = 32'h100; mem_gnt = 1; #1;
        n_cmp++; if ({instr_gnt, data_gnt} !== 2'b10) begin n_err++; $display("FAIL single_gnt: got %b want 10", {instr_gnt, data_gnt}); end
        n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL single_addr: got %h want 100", mem_addr); end
        n_cmp++; if ({mem_we, mem_wdata} !== 33'h0) begin n_err++; $display("FAIL single_we: got %b/%h want 0", mem_we, mem_wdata); end
        if (instr_gnt) sb.push_back(1'b0);
        @(negedge clk); idle_inputs(); #1;
        n_cmp++; if (outstanding !== 4'd1) begin n_err++; $display("FAIL single_out1: got %0d want 1", outstanding); end
        @(negedge clk); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
        exp_id = (sb.size() > 0) ? sb.pop_front() : 1'b1;
        n_cmp++; if ({instr_rvalid, data_rvalid} !== 2'b10 || exp_id !== 1'b0) begin
            n_err++; $display("FAIL single_rvalid: got %b want 10", {instr_rvalid, data_rvalid});
        end
        n_cmp++; if (instr_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rdata: got %h want deadbeef", instr_rdata); end
        @(negedge clk); idle_inputs(); #1;
        n_cmp++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL single_out0: got %0d want 0", outstanding); end
    endtask

    task automatic test_contention();
        bit exp_data;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            idle_inputs();
            instr_req = 1; instr_addr = 32'h200; data_req = 1; data_addr = 32'h300; mem_gnt = 1;
            mem_rvalid = (sb.size() > 0);
            #1;
            if (mem_rvalid) begin
                exp_id = sb.pop_front();
                n_cmp++; if ({instr_rvalid, data_rvalid} !== (exp_id ? 2'b01 : 2'b10)) begin
                    n_err++; $display("FAIL cont_rvalid[%0d]: got %b want id %0d", k, {instr_rvalid, data_rvalid}, exp_id);
                end
            end
            exp_data = ((k % 5) != 4);
            n_cmp++; if ({instr_gnt, data_gnt} !== {!exp_data, exp_data}) begin
                n_err++; $display("FAIL cont_gnt[%0d]: got %b want %b", k, {instr_gnt, data_gnt}, {!exp_data, exp_data});
            end
            n_cmp++; if (mem_addr !== (exp_data ? 32'h300 : 32'h200)) begin
                n_err++; $display("FAIL cont_addr[%0d]: got %h want %h", k, mem_addr, exp_data ? 32'h300 : 32'h200);
            end
            sb.push_back(exp_data);
        end
        while (sb.size() > 0) begin
            @(negedge clk); idle_inputs(); mem_rvalid = 1; #1;
            exp_id = sb.pop_front();
            n_cmp++; if ({instr_rvalid, data_rvalid} !== (exp_id ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL cont_drain: got %b want id %0d", {instr_rvalid, data_rvalid}, exp_id);
            end
        end
    endtask

    task automatic test_lock_hold();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            idle_inputs();
            data_req = (k < 4); data_addr = 32'h400; data_we = 1; data_be = 4'hA;
            data_wdata = 32'h12345678; data_wdata_intg = 7'h55;
            instr_req = (k >= 1); instr_addr = 32'h500;
            mem_gnt = (k >= 3);
            mem_rvalid = (sb.size() > 0);
            #1;
            if (mem_rvalid) begin
                exp_id = sb.pop_front();
                n_cmp++; if ({instr_rvalid, data_rvalid} !== (exp_id ? 2'b01 : 2'b10)) begin
                    n_err++; $display("FAIL lock_rvalid[%0d]: got %b want id %0d", k, {instr_rvalid, data_rvalid}, exp_id);
                end
            end
            if (k < 4) begin
                n_cmp++; if (mem_addr !== 32'h400 || mem_req !== 1'b1) begin
                    n_err++; $display("FAIL lock_addr[%0d]: got %h req %b want 400 req 1", k, mem_addr, mem_req);
                end
                n_cmp++; if ({instr_gnt, data_gnt} !== {1'b0, (k == 3)}) begin
                    n_err++; $display("FAIL lock_gnt[%0d]: got %b want 0%b", k, {instr_gnt, data_gnt}, (k == 3));
                end
                if (k == 0) begin
                    n_cmp++; if ({mem_we, mem_be, mem_wdata, mem_wdata_intg} !== {1'b1, 4'hA, 32'h12345678, 7'h55}) begin
                        n_err++; $display("FAIL lock_wpath: got %b %h %h %h", mem_we, mem_be, mem_wdata, mem_wdata_intg);
                    end
                end
                if (k == 3) sb.push_back(1'b1);
            end else begin
                n_cmp++; if ({instr_gnt, data_gnt} !== 2'b10 || mem_addr !== 32'h500) begin
                    n_err++; $display("FAIL lock_after: got gnt %b addr %h want 10/500", {instr_gnt, data_gnt}, mem_addr);
                end
                sb.push_back(1'b0);
            end
        end
        while (sb.size() > 0) begin
            @(negedge clk); idle_inputs(); mem_rvalid = 1; #1;
            exp_id = sb.pop_front();
            n_cmp++; if ({instr_rvalid, data_rvalid} !== (exp_id ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL lock_drain: got %b want id %0d", {instr_rvalid, data_rvalid}, exp_id);
            end
        end
    endtask

    task automatic test_full_fifo();
        @(negedge clk); idle_inputs(); data_req = 1; data_addr = 32'h600; mem_gnt = 1; #1;
        if (data_gnt) sb.push_back(1'b1);
        @(negedge clk); idle_inputs(); instr_req = 1; instr_addr = 32'h700; mem_gnt = 1; #1;
        if (instr_gnt) sb.push_back(1'b0);
        n_cmp++; if (sb.size() != 2) begin n_err++; $display("FAIL full_grants: got %0d want 2", sb.size()); end
        @(negedge clk); idle_inputs(); data_req = 1; data_addr = 32'h800; mem_gnt = 1; #1;
        n_cmp++; if (mem_req !== 1'b0 || data_gnt !== 1'b0) begin n_err++; $display("FAIL full_block: got req %b gnt %b want 0 0", mem_req, data_gnt); end
        n_cmp++; if (outstanding !== 4'd2) begin n_err++; $display("FAIL full_out: got %0d want 2", outstanding); end
        @(negedge clk); mem_rvalid = 1; #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL full_samecycle: got req %b want 0", mem_req); end
        exp_id = sb.pop_front();
        n_cmp++; if ({instr_rvalid, data_rvalid} !== (exp_id ? 2'b01 : 2'b10)) begin
            n_err++; $display("FAIL full_rvalid: got %b want id %0d", {instr_rvalid, data_rvalid}, exp_id);
        end
        @(negedge clk); mem_rvalid = 0; #1;
        n_cmp++; if (mem_req !== 1'b1 || data_gnt !== 1'b1 || mem_addr !== 32'h800) begin
            n_err++; $display("FAIL full_issue: got req %b gnt %b addr %h want 1 1 800", mem_req, data_gnt, mem_addr);
        end
        if (data_gnt) sb.push_back(1'b1);
        while (sb.size() > 0) begin
            @(negedge clk); idle_inputs(); mem_rvalid = 1; #1;
            exp_id = sb.pop_front();
            n_cmp++; if ({instr_rvalid, data_rvalid} !== (exp_id ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL full_drain: got %b want id %0d", {instr_rvalid, data_rvalid}, exp_id);
            end
        end
    endtask

    task automatic test_mixed_order();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle_inputs();
            instr_req = (k != 1); instr_addr = 32'h900 + k;
            data_req = (k == 1); data_addr = 32'hA00;
            mem_gnt = 1; #1;
            n_cmp++; if ({instr_gnt, data_gnt} !== ((k == 1) ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL mixed_gnt[%0d]: got %b", k, {instr_gnt, data_gnt});
            end
            sb.push_back(k == 1);
            // Leave one cycle between grants so the 2-deep FIFO still accepts the third.
            if (k == 1) begin
                @(negedge clk); idle_inputs(); mem_rvalid = 1; mem_rdata = 32'hC0DE0000; #1;
                exp_id = sb.pop_front();
                n_cmp++; if ({instr_rvalid, data_rvalid} !== (exp_id ? 2'b01 : 2'b10)) begin
                    n_err++; $display("FAIL mixed_rv_early: got %b want id %0d", {instr_rvalid, data_rvalid}, exp_id);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); idle_inputs(); mem_rvalid = 1; mem_rdata = 32'hC0DE0001 + k; mem_err = (k == 0); #1;
            exp_id = sb.pop_front();
            n_cmp++; if ({instr_rvalid, data_rvalid} !== (exp_id ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL mixed_rv[%0d]: got %b want id %0d", k, {instr_rvalid, data_rvalid}, exp_id);
            end
            n_cmp++; if (data_err !== (k == 0) || data_rvalid !== (k == 0)) begin
                n_err++; $display("FAIL mixed_err[%0d]: got err %b rvalid %b want %b", k, data_err, data_rvalid, (k == 0));
            end
        end
    endtask

    task automatic test_errors();
        @(negedge clk); idle_inputs(); mem_rvalid = 1; #1;
        n_cmp++; if ({spurious, instr_rvalid, data_rvalid} !== 3'b100) begin
            n_err++; $display("FAIL spur_pulse: got %b want 100", {spurious, instr_rvalid, data_rvalid});
        end
        @(negedge clk); idle_inputs(); #1;
        n_cmp++; if (spurious !== 1'b0 || outstanding !== 4'd0) begin
            n_err++; $display("FAIL spur_after: got %b/%0d want 0/0", spurious, outstanding);
        end
        @(negedge clk); instr_req = 1; mem_gnt = 1;
        @(negedge clk); instr_req = 0; data_req = 1;
        @(negedge clk); idle_inputs(); #1;
        n_cmp++; if (outstanding !== 4'd2) begin n_err++; $display("FAIL err_out2: got %0d want 2", outstanding); end
        #1 rst = 1'b1; #1;
        n_cmp++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL err_async_rst: got %0d want 0", outstanding); end
        sb.delete();
        @(negedge clk); rst = 1'b0;
        @(negedge clk); mem_rvalid = 1; #1;
        n_cmp++; if ({spurious, instr_rvalid, data_rvalid} !== 3'b100) begin
            n_err++; $display("FAIL err_post_rst: got %b want 100", {spurious, instr_rvalid, data_rvalid});
        end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_lock_hold();
        test_full_fifo();
        test_mixed_order();
        test_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
